// File: rtl/bram_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port block RAM between ports A and B.
// Zero-fills the RAM after reset, then registers one granted command per cycle onto the RAM pins.
module bram_arbiter #(
    parameter int RAM_WIDTH  = 16,
    parameter int RAM_DEPTH  = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [RAM_WIDTH-1:0]  a_wdata,
    output logic                  a_gnt,
    output logic [RAM_WIDTH-1:0]  a_rdata,
    output logic                  a_rvalid,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [RAM_WIDTH-1:0]  b_wdata,
    output logic                  b_gnt,
    output logic [RAM_WIDTH-1:0]  b_rdata,
    output logic                  b_rvalid,
    output logic                  init_done,
    output logic                  ram_write,
    output logic                  ram_read,
    output logic [ADDR_WIDTH-1:0] ram_add,
    output logic [RAM_WIDTH-1:0]  ram_din,
    input  logic [RAM_WIDTH-1:0]  ram_dout
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam logic [ADDR_WIDTH:0] FILL_END = (ADDR_WIDTH+1)'(RAM_DEPTH);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  init_done_q, init_done_d;
    logic                  ram_write_q, ram_write_d;
    logic                  ram_read_q, ram_read_d;
    logic [ADDR_WIDTH-1:0] ram_add_q, ram_add_d;
    logic [RAM_WIDTH-1:0]  ram_din_q, ram_din_d;
    logic                  last_b_q, last_b_d;
    logic                  pend_valid_q, pend_valid_d;
    logic                  pend_b_q, pend_b_d;
    logic                  a_rvalid_q, a_rvalid_d;
    logic                  b_rvalid_q, b_rvalid_d;
    logic                  win_we;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        init_done_d  = init_done_q;
        ram_write_d  = 1'b0;
        ram_read_d   = 1'b0;
        ram_add_d    = ram_add_q;
        ram_din_d    = ram_din_q;
        last_b_d     = last_b_q;
        pend_valid_d = 1'b0;
        pend_b_d     = pend_b_q;
        // The pending tag set at the transfer edge becomes the strobe at the RAM edge.
        a_rvalid_d   = pend_valid_q & ~pend_b_q;
        b_rvalid_d   = pend_valid_q & pend_b_q;
        a_gnt        = 1'b0;
        b_gnt        = 1'b0;
        win_we       = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                if (cnt_q == FILL_END) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end else begin
                    ram_write_d = 1'b1;
                    ram_din_d   = '0;
                    ram_add_d   = cnt_q[ADDR_WIDTH-1:0];
                    cnt_d       = cnt_q + (ADDR_WIDTH+1)'(1);
                end
            end
            ST_RUN: begin
                a_gnt = a_req & (~b_req | last_b_q);
                b_gnt = b_req & (~a_req | ~last_b_q);
                if (a_gnt || b_gnt) begin
                    win_we       = b_gnt ? b_we : a_we;
                    ram_write_d  = win_we;
                    ram_read_d   = ~win_we;
                    ram_add_d    = b_gnt ? b_addr : a_addr;
                    ram_din_d    = b_gnt ? b_wdata : a_wdata;
                    last_b_d     = b_gnt;
                    pend_valid_d = ~win_we;
                    pend_b_d     = b_gnt;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            init_done_q  <= 1'b0;
            ram_write_q  <= 1'b0;
            ram_read_q   <= 1'b0;
            ram_add_q    <= '0;
            ram_din_q    <= '0;
            last_b_q     <= 1'b1;
            pend_valid_q <= 1'b0;
            pend_b_q     <= 1'b0;
            a_rvalid_q   <= 1'b0;
            b_rvalid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            init_done_q  <= init_done_d;
            ram_write_q  <= ram_write_d;
            ram_read_q   <= ram_read_d;
            ram_add_q    <= ram_add_d;
            ram_din_q    <= ram_din_d;
            last_b_q     <= last_b_d;
            pend_valid_q <= pend_valid_d;
            pend_b_q     <= pend_b_d;
            a_rvalid_q   <= a_rvalid_d;
            b_rvalid_q   <= b_rvalid_d;
        end
    end

    assign init_done = init_done_q;
    assign ram_write = ram_write_q;
    assign ram_read  = ram_read_q;
    assign ram_add   = ram_add_q;
    assign ram_din   = ram_din_q;
    assign a_rvalid  = a_rvalid_q;
    assign b_rvalid  = b_rvalid_q;
    assign a_rdata   = ram_dout;
    assign b_rdata   = ram_dout;

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: RAM model on the RAM pins plus a round-robin/memory reference model.
module tb_bram_arbiter;

    localparam int W  = 16;
    localparam int D  = 1024;
    localparam int AW = 10;

    logic          clk, rst;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [W-1:0]  a_wdata, b_wdata;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid, init_done;
    logic [W-1:0]  a_rdata, b_rdata;
    logic          ram_write, ram_read;
    logic [AW-1:0] ram_add;
    logic [W-1:0]  ram_din, ram_dout;

    bram_arbiter #(.RAM_WIDTH(W), .RAM_DEPTH(D), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
        .init_done(init_done), .ram_write(ram_write), .ram_read(ram_read),
        .ram_add(ram_add), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM: synchronous write, registered read, write wins; contents start as garbage.
    logic [W-1:0] ram_mem [D];
    logic         ram_scrub;
    always @(posedge clk) begin
        if (ram_scrub) begin
            for (int i = 0; i < D; i++) ram_mem[i] <= W'($urandom_range(1, 65535));
        end else if (ram_write) begin
            ram_mem[ram_add] <= ram_din;
        end else if (ram_read) begin
            ram_dout <= ram_mem[ram_add];
        end
    end

    int tests = 0;
    int fails = 0;

    // Reference model: what the memory should hold, who was served last, what read is in flight.
    logic [W-1:0] m_mem [D];
    logic         m_last_b;
    logic         m_pend, m_pend_b;
    logic [W-1:0] m_pend_data;

    logic obs_ga, obs_gb, obs_arv, obs_brv, e_ga, e_gb, e_arv, e_brv;
    logic [W-1:0] obs_ard, obs_brd, e_rd;

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_mem[i] = '0;
        m_last_b    = 1'b1;
        m_pend      = 1'b0;
        m_pend_b    = 1'b0;
        m_pend_data = '0;
    endtask

    // One cycle: sample grants mid-cycle, advance past the edge, sample read returns.
    task automatic tick();
        logic          wa, wb, we;
        logic [AW-1:0] ad;
        logic [W-1:0]  dt;
        @(negedge clk);
        obs_ga = a_gnt;
        obs_gb = b_gnt;
        wa = 1'b0;
        wb = 1'b0;
        if (a_req && b_req) begin
            if (m_last_b) wa = 1'b1; else wb = 1'b1;
        end else if (a_req) wa = 1'b1;
        else if (b_req) wb = 1'b1;
        e_ga = wa;
        e_gb = wb;
        @(posedge clk);
        #1;
        obs_arv = a_rvalid;
        obs_brv = b_rvalid;
        obs_ard = a_rdata;
        obs_brd = b_rdata;
        e_arv   = m_pend && !m_pend_b;
        e_brv   = m_pend && m_pend_b;
        e_rd    = m_pend_data;
        m_pend  = 1'b0;
        if (wa || wb) begin
            we = wa ? a_we : b_we;
            ad = wa ? a_addr : b_addr;
            dt = wa ? a_wdata : b_wdata;
            if (we) m_mem[ad] = dt;
            else begin
                m_pend      = 1'b1;
                m_pend_b    = wb;
                m_pend_data = m_mem[ad];
            end
            m_last_b = wb;
        end
    endtask

    task automatic set_a(input logic req, input logic we, input logic [AW-1:0] ad, input logic [W-1:0] dt);
        a_req = req; a_we = we; a_addr = ad; a_wdata = dt;
    endtask

    task automatic set_b(input logic req, input logic we, input logic [AW-1:0] ad, input logic [W-1:0] dt);
        b_req = req; b_we = we; b_addr = ad; b_wdata = dt;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ram_scrub = 1'b1;
        set_a(1'b1, 1'b0, 10'h000, '0);
        set_b(1'b1, 1'b1, 10'h000, '0);
        repeat (2) @(posedge clk);
        #1;
        ram_scrub = 1'b0;
        tests++;
        if ({init_done, ram_write, ram_read, a_rvalid, b_rvalid, a_gnt, b_gnt} !== 7'b0 ||
            ram_add !== '0 || ram_din !== '0) begin
            fails++;
            $display("FAIL reset_state: done=%b wr=%b rd=%b rv=%b%b gnt=%b%b add=%h din=%h, want all 0",
                     init_done, ram_write, ram_read, a_rvalid, b_rvalid, a_gnt, b_gnt, ram_add, ram_din);
        end
        model_reset();
    endtask

    task automatic test_fill();
        rst = 1'b0;
        for (int n = 1; n <= D + 1; n++) begin
            a_addr = AW'($urandom);
            b_addr = AW'($urandom);
            @(negedge clk);
            tests++;
            if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin
                fails++;
                $display("FAIL fill_no_grant: edge %0d gnt a=%b b=%b, want 0 0", n, a_gnt, b_gnt);
            end
            @(posedge clk);
            #1;
            tests++;
            if (n <= D) begin
                if (ram_write !== 1'b1 || ram_read !== 1'b0 || ram_add !== AW'(n - 1) ||
                    ram_din !== '0 || init_done !== 1'b0) begin
                    fails++;
                    $display("FAIL fill_step: edge %0d wr=%b rd=%b add=%h din=%h done=%b, want 1 0 %h 0000 0",
                             n, ram_write, ram_read, ram_add, ram_din, init_done, AW'(n - 1));
                end
            end else if (ram_write !== 1'b0 || init_done !== 1'b1) begin
                fails++;
                $display("FAIL fill_end: edge %0d wr=%b done=%b, want 0 1", n, ram_write, init_done);
            end
        end
        set_a(1'b0, 1'b0, '0, '0);
        set_b(1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_single_write_read();
        for (int i = 0; i < 4; i++) begin
            if (i == 0) set_a(1'b1, 1'b1, 10'h155, 16'hBEEF);
            else if (i == 1) set_a(1'b1, 1'b0, 10'h155, 16'h0000);
            else set_a(1'b0, 1'b0, '0, '0);
            tick();
            tests++;
            if (obs_ga !== e_ga || obs_gb !== e_gb) begin
                fails++;
                $display("FAIL single_gnt[%0d]: a=%b b=%b, want %b %b", i, obs_ga, obs_gb, e_ga, e_gb);
            end
            tests++;
            if (obs_arv !== (i == 2) || obs_brv !== 1'b0) begin
                fails++;
                $display("FAIL single_rvalid[%0d]: a=%b b=%b, want %b 0", i, obs_arv, obs_brv, i == 2);
            end
            if (obs_arv) begin
                tests++;
                if (obs_ard !== 16'hBEEF) begin
                    fails++;
                    $display("FAIL single_rdata: got %h, want BEEF", obs_ard);
                end
            end
        end
    endtask

    task automatic test_contention();
        set_a(1'b1, 1'b1, 10'h001, 16'h1111);
        tick();
        set_a(1'b0, 1'b0, '0, '0);
        set_b(1'b1, 1'b1, 10'h002, 16'h2222);
        tick();
        set_a(1'b1, 1'b0, 10'h001, '0);
        set_b(1'b1, 1'b0, 10'h002, '0);
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin
                set_a(1'b0, 1'b0, '0, '0);
                set_b(1'b0, 1'b0, '0, '0);
            end
            tick();
            tests++;
            if (obs_ga !== e_ga || obs_gb !== e_gb || (i < 4 && obs_ga !== (i % 2 == 0))) begin
                fails++;
                $display("FAIL contend_gnt[%0d]: a=%b b=%b, want %b %b", i, obs_ga, obs_gb, e_ga, e_gb);
            end
            tests++;
            if (obs_arv !== e_arv || obs_brv !== e_brv) begin
                fails++;
                $display("FAIL contend_rvalid[%0d]: a=%b b=%b, want %b %b", i, obs_arv, obs_brv, e_arv, e_brv);
            end
            if (e_arv || e_brv) begin
                tests++;
                if ((e_arv ? obs_ard : obs_brd) !== (e_arv ? 16'h1111 : 16'h2222)) begin
                    fails++;
                    $display("FAIL contend_rdata[%0d]: got %h, want %h", i,
                             e_arv ? obs_ard : obs_brd, e_arv ? 16'h1111 : 16'h2222);
                end
            end
        end
    endtask

    task automatic test_fill_check();
        for (int i = 0; i < 3; i++) begin
            if (i == 0) set_b(1'b1, 1'b0, 10'h3FF, '0);
            else if (i == 1) set_b(1'b1, 1'b0, 10'h000, '0);
            else set_b(1'b0, 1'b0, '0, '0);
            tick();
            tests++;
            if (obs_brv !== (i > 0) || obs_arv !== 1'b0) begin
                fails++;
                $display("FAIL fillchk_rvalid[%0d]: a=%b b=%b, want 0 %b", i, obs_arv, obs_brv, i > 0);
            end
            if (obs_brv) begin
                tests++;
                if (obs_brd !== 16'h0000) begin
                    fails++;
                    $display("FAIL fillchk_rdata[%0d]: got %h, want 0000", i, obs_brd);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            if (i == 0) set_b(1'b1, 1'b1, 10'h0AA, 16'h00A5);
            else if (i == 1) set_b(1'b1, 1'b0, 10'h0AA, '0);
            else set_b(1'b0, 1'b0, '0, '0);
            tick();
            tests++;
            if (obs_gb !== e_gb || obs_brv !== e_brv) begin
                fails++;
                $display("FAIL b2b[%0d]: gnt=%b rvalid=%b, want %b %b", i, obs_gb, obs_brv, e_gb, e_brv);
            end
            if (i == 2) begin
                tests++;
                if (obs_brd !== 16'h00A5) begin
                    fails++;
                    $display("FAIL b2b_rdata: got %h, want 00A5", obs_brd);
                end
            end
        end
    endtask

    task automatic test_random();
        set_a(1'b0, 1'b0, '0, '0);
        set_b(1'b0, 1'b0, '0, '0);
        e_ga = 1'b0;
        e_gb = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (i >= 296) begin
                set_a(1'b0, 1'b0, '0, '0);
                set_b(1'b0, 1'b0, '0, '0);
            end else begin
                if (!a_req || e_ga)
                    set_a($urandom_range(0, 3) != 0, 1'($urandom), AW'($urandom_range(0, 15)), W'($urandom));
                if (!b_req || e_gb)
                    set_b($urandom_range(0, 3) != 0, 1'($urandom), AW'($urandom_range(0, 15)), W'($urandom));
            end
            tick();
            tests++;
            if (obs_ga !== e_ga || obs_gb !== e_gb) begin
                fails++;
                $display("FAIL rand_gnt[%0d]: a=%b b=%b, want %b %b", i, obs_ga, obs_gb, e_ga, e_gb);
            end
            tests++;
            if (obs_arv !== e_arv || obs_brv !== e_brv) begin
                fails++;
                $display("FAIL rand_rvalid[%0d]: a=%b b=%b, want %b %b", i, obs_arv, obs_brv, e_arv, e_brv);
            end
            if (e_arv || e_brv) begin
                tests++;
                if ((e_arv ? obs_ard : obs_brd) !== e_rd) begin
                    fails++;
                    $display("FAIL rand_rdata[%0d]: got %h, want %h", i, e_arv ? obs_ard : obs_brd, e_rd);
                end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int waited;
        set_a(1'b1, 1'b0, 10'h155, '0);
        tick();
        set_a(1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        #1;
        tests++;
        if (ram_read !== 1'b0 || ram_write !== 1'b0) begin
            fails++;
            $display("FAIL midrst_async: rd=%b wr=%b, want 0 0", ram_read, ram_write);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
                fails++;
                $display("FAIL midrst_rvalid[%0d]: a=%b b=%b, want 0 0", i, a_rvalid, b_rvalid);
            end
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (ram_write !== 1'b1 || ram_add !== '0 || init_done !== 1'b0 || a_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL midrst_restart: wr=%b add=%h done=%b rv=%b, want 1 000 0 0",
                     ram_write, ram_add, init_done, a_rvalid);
        end
        waited = 0;
        while (init_done !== 1'b1 && waited < D + 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        tests++;
        if (init_done !== 1'b1 || waited != D) begin
            fails++;
            $display("FAIL midrst_refill: done=%b after %0d more edges, want 1 after %0d", init_done, waited, D);
        end
        model_reset();
        for (int i = 0; i < 3; i++) begin
            set_a(i == 0, 1'b0, 10'h155, '0);
            tick();
            if (i == 1) begin
                tests++;
                if (obs_arv !== 1'b1 || obs_ard !== 16'h0000) begin
                    fails++;
                    $display("FAIL midrst_reread: rvalid=%b data=%h, want 1 0000", obs_arv, obs_ard);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_single_write_read();
        test_contention();
        test_fill_check();
        test_back_to_back();
        test_random();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
